// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: shared types and helpers for the Avalon-ST packet generator.
//   state_t       : generator FSM states (IDLE, SEND)
//   SYMBOLS       : bytes per 64-bit beat
//   EMPTY_W       : width of the empty field
//   empty_for_len : unused byte count in the EOP beat for a given length
package pkt_gen_pkg;

    localparam int SYMBOLS = 8;
    localparam int EMPTY_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // (8 - len mod 8) mod 8; only the three low length bits matter.
    function automatic logic [EMPTY_W-1:0] empty_for_len(input logic [EMPTY_W-1:0] len_lsb);
        return EMPTY_W'(4'd8 - {1'b0, len_lsb});
    endfunction

endpackage

// File: rtl/pkt_word_builder.sv
// pkt_word_builder: assembles one 64-bit beat of an incrementing-byte packet.
// Ports:
//   start_byte : value of the first byte of this beat (goes to [63:56])
//   beat_idx   : index of this beat inside the packet
//   len        : packet length in bytes
//   is_last    : this is the EOP beat; bytes at or past len are zeroed
//   data       : assembled beat
module pkt_word_builder
    import pkt_gen_pkg::*;
#(
    parameter int LEN_W = 12
) (
    input  logic [7:0]       start_byte,
    input  logic [LEN_W-4:0] beat_idx,
    input  logic [LEN_W-1:0] len,
    input  logic             is_last,
    output logic [63:0]      data
);

    // Lay out the eight bytes, first byte in the top lane, zero padding past len
    always_comb begin
        data = 64'd0;
        for (int j = 0; j < SYMBOLS; j++) begin
            // {beat_idx, j} is the absolute byte position, beat_idx*8 + j
            if (!is_last || ({beat_idx, 3'(j)} < len)) begin
                data[63-8*j -: 8] = start_byte + 8'(j);
            end else begin
                data[63-8*j -: 8] = 8'd0;
            end
        end
    end

endmodule

// File: rtl/ast_packet_gen.sv
// ast_packet_gen: Avalon-ST packet source. Accepts one descriptor at a time
// (length, channel, seed) and emits the packet as 64-bit beats whose bytes
// count up from the seed, with SOP/EOP/empty/channel and backpressure.
// Ports:
//   clk_i, arst_i          : clock, asynchronous active-high reset
//   cmd_valid_i/ready_o    : descriptor handshake
//   cmd_len_i/channel_i/seed_i : descriptor fields
//   ast_ready_i            : sink ready (ready latency 0)
//   ast_data_o/valid_o/startofpacket_o/endofpacket_o/empty_o/channel_o : stream
//   pkt_cnt_o              : completed-packet counter, only when the macro
//                            PKT_GEN_STATS_EN is defined
// All outputs are registered.
module ast_packet_gen
    import pkt_gen_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int LEN_W  = 12
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic               cmd_channel_i,
    input  logic [7:0]         cmd_seed_i,
    input  logic               ast_ready_i,
    output logic [DWIDTH-1:0]  ast_data_o,
    output logic               ast_valid_o,
    output logic               ast_startofpacket_o,
    output logic               ast_endofpacket_o,
    output logic [EMPTY_W-1:0] ast_empty_o,
    output logic               ast_channel_o
`ifdef PKT_GEN_STATS_EN
    ,
    output logic [31:0]        pkt_cnt_o
`endif
);

    localparam int BW = LEN_W - 3;

    state_t             state_r, state_s;
    logic               cmd_ready_r, cmd_ready_s;
    logic [DWIDTH-1:0]  data_r, data_s;
    logic               valid_r, valid_s;
    logic               sop_r, sop_s;
    logic               eop_r, eop_s;
    logic [EMPTY_W-1:0] empty_r, empty_s;
    logic               channel_r, channel_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic [7:0]         next_byte_r, next_byte_s;
    logic [BW-1:0]      beat_r, beat_s;
    logic [BW-1:0]      last_beat_r, last_beat_s;

    logic [7:0]         bld_start_s;
    logic [BW-1:0]      bld_idx_s;
    logic [LEN_W-1:0]   bld_len_s;
    logic               bld_last_s;
    logic [63:0]        bld_data_s;
    logic [BW-1:0]      cmd_last_s;

    // Index of the final beat of the offered descriptor, ceil(len/8)-1
    always_comb begin
        if (cmd_len_i != {LEN_W{1'b0}}) begin
            cmd_last_s = BW'((cmd_len_i - LEN_W'(1)) >> 3);
        end else begin
            cmd_last_s = {BW{1'b0}};
        end
    end

    pkt_word_builder #(.LEN_W(LEN_W)) u_builder (
        .start_byte (bld_start_s),
        .beat_idx   (bld_idx_s),
        .len        (bld_len_s),
        .is_last    (bld_last_s),
        .data       (bld_data_s)
    );

    // Next-state and next-output logic; the builder sees either the incoming
    // descriptor (first beat) or the registered packet state (later beats)
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = cmd_ready_r;
        data_s      = data_r;
        valid_s     = valid_r;
        sop_s       = sop_r;
        eop_s       = eop_r;
        empty_s     = empty_r;
        channel_s   = channel_r;
        len_s       = len_r;
        next_byte_s = next_byte_r;
        beat_s      = beat_r;
        last_beat_s = last_beat_r;
        bld_start_s = next_byte_r;
        bld_idx_s   = beat_r + BW'(1);
        bld_len_s   = len_r;
        bld_last_s  = ((beat_r + BW'(1)) == last_beat_r);

        case (state_r)
            IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_ready_r && cmd_valid_i && (cmd_len_i != {LEN_W{1'b0}})) begin
                    bld_start_s = cmd_seed_i;
                    bld_idx_s   = {BW{1'b0}};
                    bld_len_s   = cmd_len_i;
                    bld_last_s  = (cmd_last_s == {BW{1'b0}});
                    state_s     = SEND;
                    cmd_ready_s = 1'b0;
                    data_s      = bld_data_s;
                    valid_s     = 1'b1;
                    sop_s       = 1'b1;
                    eop_s       = bld_last_s;
                    empty_s     = bld_last_s ? empty_for_len(cmd_len_i[2:0]) : 3'd0;
                    channel_s   = cmd_channel_i;
                    len_s       = cmd_len_i;
                    next_byte_s = cmd_seed_i + 8'd8;
                    beat_s      = {BW{1'b0}};
                    last_beat_s = cmd_last_s;
                end else begin
                    // Zero-length descriptors are consumed here without output
                    state_s = IDLE;
                    valid_s = 1'b0;
                end
            end
            SEND: begin
                cmd_ready_s = 1'b0;
                if (ast_ready_i) begin
                    if (eop_r) begin
                        state_s     = IDLE;
                        cmd_ready_s = 1'b1;
                        data_s      = {DWIDTH{1'b0}};
                        valid_s     = 1'b0;
                        sop_s       = 1'b0;
                        eop_s       = 1'b0;
                        empty_s     = 3'd0;
                        channel_s   = 1'b0;
                    end else begin
                        data_s      = bld_data_s;
                        sop_s       = 1'b0;
                        eop_s       = bld_last_s;
                        empty_s     = bld_last_s ? empty_for_len(len_r[2:0]) : 3'd0;
                        beat_s      = beat_r + BW'(1);
                        next_byte_s = next_byte_r + 8'd8;
                    end
                end else begin
                    // Backpressure: every stream output holds
                    state_s = SEND;
                end
            end
            default: begin
                state_s     = IDLE;
                cmd_ready_s = 1'b0;
                valid_s     = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output and packet-context registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cmd_ready_r <= 1'b0;
            data_r      <= {DWIDTH{1'b0}};
            valid_r     <= 1'b0;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
            empty_r     <= 3'd0;
            channel_r   <= 1'b0;
            len_r       <= {LEN_W{1'b0}};
            next_byte_r <= 8'd0;
            beat_r      <= {BW{1'b0}};
            last_beat_r <= {BW{1'b0}};
        end else begin
            cmd_ready_r <= cmd_ready_s;
            data_r      <= data_s;
            valid_r     <= valid_s;
            sop_r       <= sop_s;
            eop_r       <= eop_s;
            empty_r     <= empty_s;
            channel_r   <= channel_s;
            len_r       <= len_s;
            next_byte_r <= next_byte_s;
            beat_r      <= beat_s;
            last_beat_r <= last_beat_s;
        end
    end

    assign cmd_ready_o         = cmd_ready_r;
    assign ast_data_o          = data_r;
    assign ast_valid_o         = valid_r;
    assign ast_startofpacket_o = sop_r;
    assign ast_endofpacket_o   = eop_r;
    assign ast_empty_o         = empty_r;
    assign ast_channel_o       = channel_r;

`ifdef PKT_GEN_STATS_EN
    logic [31:0] pkt_cnt_r;

    // Count completed packets (EOP transfers); wraps naturally at 2**32
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pkt_cnt_r <= 32'd0;
        end else if ((state_r == SEND) && ast_ready_i && eop_r) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign pkt_cnt_o = pkt_cnt_r;
`endif

endmodule
